// File: rtl/nerv_dbridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nerv_dbridge_pkg
// Purpose  : Shared types and constants for the nerv data-port bridge.
// Revision : 1.0 - initial release
// ============================================================================
package nerv_dbridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        RETURN = 3'd4
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;
    localparam logic [3:0]  WSTRB_READ        = 4'h0;
    localparam int          TIMER_W           = 16;

    function automatic logic is_read(input logic [3:0] wstrb);
        return (wstrb == WSTRB_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nerv_dbridge_timer.sv
`default_nettype none
// ============================================================================
// Module   : nerv_dbridge_timer
// Purpose  : Response watchdog; expire pulses on the LIMIT-th enabled cycle
//            after clear.
// Revision : 1.0 - initial release
// ============================================================================
module nerv_dbridge_timer
    import nerv_dbridge_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMER_W-1:0] c_last = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/nerv_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : nerv_dmem_bridge
// Purpose  : Turns nerv's zero-wait data port into a valid/ready request plus
//            rvalid response bus, stalling the core until each access ends.
//            NERV_DBRIDGE_TIMEOUT_EN adds a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module nerv_dmem_bridge
    import nerv_dbridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        timeout
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout_cycles
        $error("nerv_dmem_bridge: TIMEOUT_CYCLES must lie in 1..65535");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic        w_capture_req;
    logic        w_capture_rsp;
    logic        w_timed_out;
    logic        w_expire;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A response accepted on the expiry cycle still counts as a normal completion.
    always_comb begin
        w_state_next  = r_state;
        w_capture_req = 1'b0;
        w_capture_rsp = 1'b0;
        w_timed_out   = 1'b0;
        case (r_state)
            IDLE: begin
                if (dmem_valid) begin
                    w_capture_req = 1'b1;
                    w_state_next  = REQ;
                end
            end
            REQ: begin
                if (bus_ready && bus_rvalid) begin
                    w_capture_rsp = 1'b1;
                    w_state_next  = DONE;
                end else if (w_expire) begin
                    w_timed_out  = 1'b1;
                    w_state_next = DONE;
                end else if (bus_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    w_capture_rsp = 1'b1;
                    w_state_next  = DONE;
                end else if (w_expire) begin
                    w_timed_out  = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = is_read(r_wstrb) ? RETURN : IDLE;
            end
            RETURN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
            r_rdata_q <= '0;
        end else begin
            if (w_capture_req) begin
                r_addr  <= dmem_addr;
                r_wstrb <= dmem_wstrb;
                r_wdata <= dmem_wdata;
            end
            if (w_capture_rsp && is_read(r_wstrb)) begin
                r_rdata_q <= bus_rdata;
            end else if (w_timed_out && is_read(r_wstrb)) begin
                r_rdata_q <= ERR_RDATA;
            end
        end
    end

`ifdef NERV_DBRIDGE_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_en;
    logic r_timeout;

    assign w_timer_clear = (r_state == IDLE) && dmem_valid;
    assign w_timer_en    = (r_state == REQ) || (r_state == WAIT);

    nerv_dbridge_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (w_timer_clear),
        .enable (w_timer_en),
        .expire (w_expire)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_timeout <= 1'b0;
        end else if (w_timed_out) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // dmem_valid -> stall is the only combinational path through the bridge.
    assign stall      = ((r_state == IDLE) && dmem_valid) || (r_state == REQ) || (r_state == WAIT);
    assign bus_valid  = (r_state == REQ);
    assign bus_addr   = r_addr;
    assign bus_wstrb  = r_wstrb;
    assign bus_wdata  = r_wdata;
    assign dmem_rdata = r_rdata_q;

endmodule
`default_nettype wire
